int_to_float_sched: RTL and testbench
=====================================

# int_to_float_sched

Shares one sequential 8-bit signed-integer-to-IEEE-754-single converter among `NUM_REQ` requesters. A round-robin arbiter picks one requester. A small FSM then normalises the magnitude one bit per cycle and returns the 32-bit float to a single consumer, tagged with the requester ID. The block sits between integer producers (switch inputs, counters) and the FPU output/display path.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2–8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `req_valid` input, `NUM_REQ` bits: bit i means requester i holds an operand.
- `req_data` input, `NUM_REQ*8` bits: requester i's operand is in bits `[8i+7:8i]`, 2's complement.
- `req_ready` output, `NUM_REQ` bits: one-hot; bit i means requester i's operand is accepted this cycle.
- `out_valid` output, 1 bit: `out_float` and `out_id` are valid.
- `out_float` output, 32 bits: result as {sign, exponent[7:0], mantissa[22:0]}.
- `out_id` output, `ID_W` bits: index of the requester that produced the result.
- `out_ready` input, 1 bit: the consumer accepts the result.

## Operation
- **States**: `IDLE`, `NORM`, `DONE`. Only one conversion is in flight at a time; there is no input buffering.
- **IDLE**:
  - Grant goes to the first i with `req_valid[i]=1`, searching from `last_grant+1` mod `NUM_REQ` upward with wrap-around.
  - `req_ready` is combinational and one-hot at the granted index; it is all-zero when no requester is valid or the state is not `IDLE`.
  - On the handshake (`req_valid[g] & req_ready[g]`), the block registers:
    - `sign = data[7]`;
    - `mag = sign ? (~data + 1) : data` as 8-bit unsigned, so -128 gives 0x80;
    - `id = g`;
    - `exp = 134`;
    - `last_grant = g`.
  - Next state is `NORM`, or `DONE` if `mag == 0`. A zero input produces `out_float = 0x00000000`.
- **NORM**, evaluated each cycle:
  - If `mag[7]=1`: load `out_float = {sign, exp, mag[6:0], 16'b0}` and go to `DONE`.
  - Otherwise: `mag <= mag << 1` and `exp <= exp - 1`.
  - `exp` never drops below 127, because a nonzero 8-bit magnitude needs at most 7 shifts.
- **DONE**:
  - `out_valid=1`; `out_float` and `out_id` are held stable.
  - On `out_ready=1`, go to `IDLE`; `out_valid` is 0 the next cycle.
  - No requester is accepted while in `DONE`.
- **Fairness**: `last_grant` updates only on a completed input handshake. A requester that drops `req_valid` before being granted simply loses its turn; no error is flagged.
- **Requester contract**: `req_data` must be stable while `req_valid` is high.

## Timing
- **Reset** (asynchronous, effective immediately, including mid-`NORM` or mid-`DONE`):
  - state `IDLE`, `out_valid=0`, `out_float=0`, `out_id=0`, `req_ready=0`;
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority;
  - any in-flight result is discarded.
- **Latency**: input handshake at cycle T, with `lz` = number of leading zeros of `mag`.
  - Nonzero operand: `out_valid` first high at T+lz+2. Examples: -128 at T+2, 1 at T+9.
  - Zero operand: `out_valid` high at T+1.
- **Throughput**: with `out_ready` tied high, the next input handshake can occur at the earliest one cycle after `DONE` exits. One conversion occupies lz+3 cycles (zero: 2 cycles).
- **Backpressure**: `out_valid` stays high indefinitely while `out_ready=0`; outputs do not change.
- **Boundary conditions**:
  - All `req_valid` low in `IDLE`: remain in `IDLE` and `last_grant` is unchanged.
  - `out_ready` already high when `DONE` is entered: exactly one cycle of `out_valid`.

## Test plan
- **Single conversions**: requester 0 sends 5, 127, 1, -1, -128 in turn, with `out_ready=1`.
  - Required `out_float`: 0x40A00000, 0x42FE0000, 0x3F800000, 0xBF800000, 0xC3000000.
  - Required `out_valid` cycle (T = handshake): T+7, T+3, T+9, T+9, T+2.
  - `out_id` = 0 for all.
- **Zero**: send 0 → `out_float = 0x00000000` with `out_valid` at T+1; send 0x00 with sign 0, and check no `NORM` cycles occur.
- **Round-robin**: all four requesters valid continuously, each with distinct data.
  - Grants follow 0,1,2,3,0,1 after reset.
  - `out_id` matches each grant and `req_ready` is always one-hot.
- **Backpressure**: hold `out_ready=0` for 10 cycles after `out_valid` rises.
  - `out_valid`, `out_float` and `out_id` stay stable.
  - `req_ready` stays 0 throughout.
  - On release, `IDLE` is re-entered and the next grant follows.
- **Reset mid-operation**: assert `reset` during `NORM` while converting 1.
  - Outputs reach their reset values without waiting for a clock edge.
  - After release, requester 0 is granted first when all requesters are valid.
- **Sparse requests**: only requester 2 is valid, repeatedly.
  - It is granted every conversion.
  - `last_grant` stays 2, with no grant to idle requesters.

Source files
------------

// File: rtl/int_to_float_sched.sv
// Shared 8-bit signed int -> IEEE-754 single converter, round-robin arbitrated
// among NUM_REQ requesters; normalises one bit per cycle and tags results with the requester id.
module int_to_float_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [31:0]          out_float,
    output logic [ID_W-1:0]      out_id,
    input  logic                 out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [7:0]      grant_data;
    logic [7:0]      grant_mag;
    logic            sign;
    logic [7:0]      mag;
    logic [7:0]      exp_q;
    int              cand;

    // Search starts one past the last accepted requester so every valid one gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        grant_data  = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
                grant_data  = req_data[8*cand +: 8];
            end
        end
    end

    // -128 negates to 0x80, which is exactly the right unsigned magnitude.
    assign grant_mag = grant_data[7] ? (~grant_data + 8'd1) : grant_data;

    always_comb begin
        req_ready = '0;
        if (!reset && state == IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            out_float  <= '0;
            out_id     <= '0;
            sign       <= 1'b0;
            mag        <= '0;
            exp_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        sign       <= grant_data[7];
                        mag        <= grant_mag;
                        exp_q      <= 8'd134;
                        out_id     <= grant_idx;
                        last_grant <= grant_idx;
                        if (grant_mag == 8'd0) begin
                            out_float <= '0;
                            state     <= DONE;
                        end else begin
                            state     <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[7]) begin
                        out_float <= {sign, exp_q, mag[6:0], 16'b0};
                        state     <= DONE;
                    end else begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_sched.sv
// Scoreboard bench for int_to_float_sched: expected float/id/arrival cycle are queued at each
// input handshake and compared when the converter presents a result.
module tb_int_to_float_sched;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [31:0]    out_float;
    logic [IW-1:0]  out_id;
    logic           out_ready;

    int_to_float_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_float(out_float), .out_id(out_id),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   fl;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_last = N - 1;
    bit   seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference conversion: locate the leading one directly rather than shifting.
    function automatic int msb_pos(input logic [7:0] m);
        int p = -1;
        for (int i = 0; i < 8; i++) if (m[i]) p = i;
        return p;
    endfunction

    function automatic logic [7:0] magof(input logic [7:0] d);
        logic [7:0] m;
        m = d[7] ? 8'(0 - int'(d)) : d;
        return m;
    endfunction

    function automatic logic [31:0] i2f(input logic [7:0] d);
        logic [7:0]  m;
        logic [22:0] mt;
        int          p;
        m = magof(d);
        p = msb_pos(m);
        if (p < 0) return 32'h0;
        mt = 23'(m) << (23 - p);
        return {d[7], 8'(127 + p), mt};
    endfunction

    function automatic int lat(input logic [7:0] d);
        int p = msb_pos(magof(d));
        return (p < 0) ? 1 : (7 - p) + 2;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int         g;
        logic [7:0] d;
        if (!reset) begin
            chk("req_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if ((req_valid & req_ready) != '0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                chk("grant", g, rr_pick(req_valid, exp_last));
                exp_last = g;
                grant_log.push_back(g);
                d = req_data[8*g +: 8];
                sb.push_back('{id: IW'(g), fl: i2f(d), due: cyc + lat(d)});
            end
            if (out_valid) begin
                chk("req_ready_in_done", req_ready, '0);
                chk("result_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    if (!seen) begin
                        chk("latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    chk("out_float", out_float, sb[0].fl);
                    chk("out_id", out_id, sb[0].id);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input int r, input logic [7:0] d);
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_data[8*r +: 8] = d;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
        end
        chk("send_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) ok = 1'b1;
        end
        chk("drain", 32'(ok), 32'd1);
    endtask

    task automatic wait_grants(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            if (grant_log.size() >= n) ok = 1'b1;
        end
        chk("grant_wait", 32'(ok), 32'd1);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_float"}, out_float, 32'd0);
        chk({tag, "_out_id"}, 32'(out_id), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        seen = 1'b0;
        exp_last = N - 1;
    endtask

    logic [7:0] singles [5] = '{8'd5, 8'd127, 8'd1, 8'hFF, 8'h80};
    int         rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        #1 reset = 1'b1;
        req_valid = '1;
        #2 check_reset_outputs("por");
        req_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (singles[i]) begin
            send(0, singles[i]);
            drain();
        end
        send(0, 8'd0);
        drain();

        // Round-robin from a fresh reset, all requesters continuously valid
        @(posedge clk); #1 reset = 1'b1;
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        grant_log.delete();
        req_data  = {8'd0, 8'd64, 8'hF9, 8'd3};
        req_valid = '1;
        wait_grants(6);
        req_valid = '0;
        drain();
        foreach (rr_exp[i]) chk("rr_order", grant_log[i], rr_exp[i]);

        // Backpressure: requester 3 waits while the result is held
        out_ready = 1'b0;
        send(1, 8'hDB);
        req_data[8*3 +: 8] = 8'd17;
        req_valid[3] = 1'b1;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (out_valid) ok = 1'b1;
            end
            chk("bp_valid_rise", 32'(ok), 32'd1);
        end
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        grant_log.delete();
        wait_grants(1);
        req_valid[3] = 1'b0;
        drain();
        chk("bp_next_grant", grant_log[0], 3);

        // Asynchronous reset while converting 1 (mid-normalisation)
        send(0, 8'd1);
        repeat (2) @(posedge clk);
        req_data  = {8'd9, 8'd8, 8'd7, 8'd6};
        req_valid = '1;
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        model_reset();
        grant_log.delete();
        @(posedge clk); #1 reset = 1'b0;
        wait_grants(1);
        req_valid = '0;
        drain();
        chk("post_reset_grant", grant_log[0], 0);

        // Sparse: only requester 2 ever valid
        grant_log.delete();
        send(2, 8'd42);
        drain();
        send(2, 8'hC0);
        drain();
        send(2, 8'd2);
        drain();
        chk("sparse_count", grant_log.size(), 3);
        foreach (grant_log[i]) chk("sparse_grant", grant_log[i], 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
